// File: rtl/cache_pkg.sv
// Shared encodings and geometry helpers for the associative L1 cache controller.
package cache_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COMPARE   = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_ALLOCATE  = 2'd3;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w,
                                              input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned num_sets(input int unsigned index_w);
        return 32'd1 << index_w;
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Per-set tag/valid/dirty/LRU storage: asynchronous read by index, synchronous update,
// asynchronous clear on reset and single-cycle bulk clear of line state.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 21,
    parameter int unsigned WAYS    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [INDEX_W-1:0]         index,
    output logic [WAYS-1:0][TAG_W-1:0] rd_tag,
    output logic [WAYS-1:0]            rd_valid,
    output logic [WAYS-1:0]            rd_dirty,
    output logic                       rd_lru,
    input  logic                       fill_en,
    input  logic                       fill_way,
    input  logic [TAG_W-1:0]           fill_tag,
    input  logic                       dirty_set_en,
    input  logic                       dirty_clr_en,
    input  logic                       dirty_way,
    input  logic                       lru_en,
    input  logic                       lru_way
);

    localparam int unsigned SETS = num_sets(INDEX_W);

    logic [WAYS-1:0][TAG_W-1:0] tags  [SETS];
    logic [WAYS-1:0]            valid [SETS];
    logic [WAYS-1:0]            dirty [SETS];
    logic [SETS-1:0]            lru;

    assign rd_tag   = tags[index];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_lru   = lru[index];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                tags[s]  <= '0;
                valid[s] <= '0;
                dirty[s] <= '0;
            end
            lru <= '0;
        end else if (clear) begin
            // Tags are left as-is; clearing valid is enough to make them unreachable.
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
            end
            lru <= '0;
        end else begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (fill_en && fill_way == 1'(w)) begin
                    tags[index][w]  <= fill_tag;
                    valid[index][w] <= 1'b1;
                    dirty[index][w] <= 1'b0;
                end
                if (dirty_set_en && dirty_way == 1'(w)) begin
                    dirty[index][w] <= 1'b1;
                end
                if (dirty_clr_en && dirty_way == 1'(w)) begin
                    dirty[index][w] <= 1'b0;
                end
            end
            if (lru_en) begin
                lru[index] <= lru_way;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// Write-back, write-allocate L1 cache controller, 1- or 2-way set-associative with LRU victim choice.
module cache_ctrl_assoc
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic               inv_all,
    input  logic               l2_ack,
    input  logic               write_done,
    output logic               cpu_ready,
    output logic               hit,
    output logic               miss,
    output logic [INDEX_W-1:0] l1_index,
    output logic               l1_way,
    output logic               l1_we,
    output logic               l1_fill,
    output logic [ADDR_W-1:0]  l2_addr,
    output logic               write_l2,
    output logic               read_l2,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int unsigned BLK_W = ADDR_W - OFFSET_W;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("cache_ctrl_assoc: WAYS must be 1 or 2");
    end

    logic [1:0]       state;
    logic [BLK_W-1:0] req_blk;
    logic             req_we;
    logic             first_look;
    logic             vic_way;
    logic [TAG_W-1:0] vic_tag;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;

    assign req_tag   = req_blk[BLK_W-1 -: TAG_W];
    assign req_index = req_blk[INDEX_W-1:0];

    logic [WAYS-1:0][TAG_W-1:0] rd_tag;
    logic [WAYS-1:0]            rd_valid;
    logic [WAYS-1:0]            rd_dirty;
    logic                       rd_lru;

    logic             fill_en;
    logic             dirty_set_en;
    logic             dirty_clr_en;
    logic             dirty_way;
    logic             lru_en;
    logic             tag_clear;

    logic [WAYS-1:0]  hit_vec;
    logic             any_hit;
    logic             hit_way;
    logic             vic_sel;
    logic             vic_needs_wb;
    logic [TAG_W-1:0] vic_tag_sel;

    cache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .WAYS    (WAYS)
    ) u_tags (
        .clk          (clk),
        .reset        (reset),
        .clear        (tag_clear),
        .index        (req_index),
        .rd_tag       (rd_tag),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_lru       (rd_lru),
        .fill_en      (fill_en),
        .fill_way     (vic_way),
        .fill_tag     (req_tag),
        .dirty_set_en (dirty_set_en),
        .dirty_clr_en (dirty_clr_en),
        .dirty_way    (dirty_way),
        .lru_en       (lru_en),
        .lru_way      (~hit_way)
    );

    always_comb begin
        hit_vec = '0;
        hit_way = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
            if (hit_vec[w]) begin
                hit_way = 1'(w);
            end
        end
        any_hit = |hit_vec;
    end

    // Lowest invalid way first; only a fully valid set falls back to LRU.
    always_comb begin
        if (WAYS == 1) begin
            vic_sel = 1'b0;
        end else if (!rd_valid[0]) begin
            vic_sel = 1'b0;
        end else if (!rd_valid[WAYS-1]) begin
            vic_sel = 1'b1;
        end else begin
            vic_sel = rd_lru;
        end
        vic_needs_wb = 1'b0;
        vic_tag_sel  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (vic_sel == 1'(w)) begin
                vic_needs_wb = rd_valid[w] && rd_dirty[w];
                vic_tag_sel  = rd_tag[w];
            end
        end
    end

    always_comb begin
        tag_clear    = (state == ST_IDLE) && inv_all;
        fill_en      = (state == ST_ALLOCATE) && l2_ack;
        dirty_set_en = (state == ST_COMPARE) && any_hit && req_we;
        dirty_clr_en = (state == ST_WRITEBACK) && write_done;
        dirty_way    = (state == ST_WRITEBACK) ? vic_way : hit_way;
        lru_en       = (WAYS == 2) && (state == ST_COMPARE) && any_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_blk    <= '0;
            req_we     <= 1'b0;
            first_look <= 1'b0;
            vic_way    <= 1'b0;
            vic_tag    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!inv_all && cpu_req) begin
                        req_blk    <= cpu_addr[ADDR_W-1:OFFSET_W];
                        req_we     <= cpu_we;
                        first_look <= 1'b1;
                        state      <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    first_look <= 1'b0;
                    if (any_hit) begin
                        if (first_look && hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        if (first_look && miss_cnt != '1) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                        vic_way <= vic_sel;
                        vic_tag <= vic_tag_sel;
                        state   <= vic_needs_wb ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    if (write_done) begin
                        state <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (l2_ack) begin
                        state <= ST_COMPARE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state so an async reset drops them without a clock edge.
    always_comb begin
        hit      = (state == ST_COMPARE) && any_hit;
        cpu_ready = hit;
        miss     = (state == ST_COMPARE) && !any_hit && first_look;
        l1_we    = hit && req_we;
        l1_fill  = (state == ST_ALLOCATE) && l2_ack;
        write_l2 = (state == ST_WRITEBACK);
        read_l2  = (state == ST_ALLOCATE);
        l1_index = req_index;
        case (state)
            ST_COMPARE:               l1_way = hit_way;
            ST_WRITEBACK, ST_ALLOCATE: l1_way = vic_way;
            default:                  l1_way = 1'b0;
        endcase
        case (state)
            ST_WRITEBACK: l2_addr = {vic_tag, req_index, {OFFSET_W{1'b0}}};
            ST_ALLOCATE:  l2_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
            default:      l2_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Randomised and directed bench for cache_ctrl_assoc against a line-level cache model.
module tb_cache_ctrl_assoc;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset, cpu_req, cpu_we, inv_all, l2_ack, write_done;
    logic [31:0] cpu_addr;
    logic        cpu_ready, hit, miss, l1_way, l1_we, l1_fill, write_l2, read_l2;
    logic [5:0]  l1_index;
    logic [31:0] l2_addr;
    logic [CW-1:0] hit_cnt, miss_cnt;

    cache_ctrl_assoc #(
        .ADDR_W   (32),
        .INDEX_W  (6),
        .OFFSET_W (5),
        .WAYS     (2),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .inv_all    (inv_all),
        .l2_ack     (l2_ack),
        .write_done (write_done),
        .cpu_ready  (cpu_ready),
        .hit        (hit),
        .miss       (miss),
        .l1_index   (l1_index),
        .l1_way     (l1_way),
        .l1_we      (l1_we),
        .l1_fill    (l1_fill),
        .l2_addr    (l2_addr),
        .write_l2   (write_l2),
        .read_l2    (read_l2),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: per set, two ways of {valid, dirty, tag}; lru[s] names the way to evict next.
    bit          mv  [64][2];
    bit          md  [64][2];
    logic [20:0] mt  [64][2];
    int          ml  [64];
    int          mhit, mmiss;

    function automatic void model_clear_lines();
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
            ml[s] = 0;
        end
    endfunction

    function automatic void model_touch(input int s, input int w, input logic we);
        if (we) md[s][w] = 1'b1;
        ml[s] = 1 - w;
    endfunction

    // One CPU access with a 3-cycle L2; both=1 also raises l2_ack alongside write_done.
    task automatic access(input logic [31:0] a, input logic we, input bit both, input string nm);
        int s, hw, v;
        logic [20:0] t;
        logic [31:0] ea;
        logic [6:0]  obs, ex;
        s  = int'(a[10:5]);
        t  = a[31:11];
        hw = -1;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a;
        @(posedge clk); @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom;
        #1;
        n_vec++;
        if (l1_index !== a[10:5]) begin
            n_err++; $display("FAIL %s l1_index: got %h want %h", nm, l1_index, a[10:5]);
        end
        obs = {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2};
        if (hw >= 0) begin
            ex = {1'b1, 1'b0, 1'b1, we, 3'b000};
            n_vec++;
            if (obs !== ex || l1_way !== 1'(hw)) begin
                n_err++; $display("FAIL %s hit_look: flags %b way %b want %b way %b", nm, obs, l1_way, ex, 1'(hw));
            end
            if (mhit < CNTMAX) mhit++;
            model_touch(s, hw, we);
        end else begin
            ex = 7'b0100000;
            n_vec++;
            if (obs !== ex) begin
                n_err++; $display("FAIL %s miss_look: flags %b want %b", nm, obs, ex);
            end
            if (mmiss < CNTMAX) mmiss++;
            v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : ml[s]);
            @(posedge clk); @(negedge clk);
            if (mv[s][v] && md[s][v]) begin
                ea = {mt[s][v], a[10:5], 5'b0};
                for (int k = 0; k < 3; k++) begin
                    write_done = (k == 2);
                    l2_ack     = both && (k == 2);
                    #1;
                    obs = {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2};
                    n_vec++;
                    if (obs !== 7'b0000010 || l2_addr !== ea) begin
                        n_err++; $display("FAIL %s writeback[%0d]: flags %b addr %h want 0000010 addr %h", nm, k, obs, l2_addr, ea);
                    end
                    @(posedge clk); @(negedge clk);
                end
                write_done = 1'b0; l2_ack = 1'b0;
                md[s][v] = 1'b0;
            end
            ea = {t, a[10:5], 5'b0};
            for (int k = 0; k < 3; k++) begin
                l2_ack = (k == 2);
                #1;
                obs = {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2};
                ex  = {4'b0000, (k == 2), 2'b01};
                n_vec++;
                if (obs !== ex || l2_addr !== ea || (k == 2 && l1_way !== 1'(v))) begin
                    n_err++; $display("FAIL %s allocate[%0d]: flags %b addr %h way %b want %b addr %h way %b", nm, k, obs, l2_addr, l1_way, ex, ea, 1'(v));
                end
                @(posedge clk); @(negedge clk);
            end
            l2_ack = 1'b0;
            #1;
            mt[s][v] = t; mv[s][v] = 1'b1; md[s][v] = 1'b0;
            obs = {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2};
            ex  = {1'b1, 1'b0, 1'b1, we, 3'b000};
            n_vec++;
            if (obs !== ex || l1_way !== 1'(v)) begin
                n_err++; $display("FAIL %s relook: flags %b way %b want %b way %b", nm, obs, l1_way, ex, 1'(v));
            end
            model_touch(s, v, we);
        end
        @(posedge clk); @(negedge clk);
        #1;
        n_vec++;
        if (cpu_ready !== 1'b0 || hit_cnt !== CW'(mhit) || miss_cnt !== CW'(mmiss)) begin
            n_err++; $display("FAIL %s done: ready %b hits %0d misses %0d want 0 %0d %0d", nm, cpu_ready, hit_cnt, miss_cnt, mhit, mmiss);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        inv_all = 1'b0; l2_ack = 1'b0; write_done = 1'b0;
        model_clear_lines(); mhit = 0; mmiss = 0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2, l1_way} !== 8'h00 ||
            l2_addr !== 32'h0 || hit_cnt !== '0 || miss_cnt !== '0 || l1_index !== 6'h0) begin
            n_err++; $display("FAIL reset_state: flags %b addr %h cnt %0d/%0d", {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2, l1_way}, l2_addr, hit_cnt, miss_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_cold_load();
        access(32'h0000_1040, 1'b0, 1'b0, "cold_load");
        n_vec++;
        if (miss_cnt !== CW'(1) || hit_cnt !== CW'(0)) begin
            n_err++; $display("FAIL cold_load_counts: hits %0d misses %0d want 0 1", hit_cnt, miss_cnt);
        end
    endtask

    task automatic test_store_hit();
        access(32'h0000_1040, 1'b1, 1'b0, "store_hit");
        n_vec++;
        if (hit_cnt !== CW'(1)) begin
            n_err++; $display("FAIL store_hit_count: hits %0d want 1", hit_cnt);
        end
    endtask

    task automatic test_victim();
        access(32'h0000_2040, 1'b0, 1'b0, "fill_way1");
        access(32'h0000_1040, 1'b1, 1'b0, "store_way0");
        access(32'h0000_4040, 1'b0, 1'b0, "clean_victim");
        access(32'h0000_8040, 1'b0, 1'b0, "dirty_victim");
    endtask

    task automatic test_wb_ack_overlap();
        access(32'h0000_4040, 1'b1, 1'b0, "dirty_w1");
        access(32'h0000_8040, 1'b1, 1'b0, "dirty_w0");
        access(32'h0000_C040, 1'b0, 1'b1, "wb_ack_overlap");
    endtask

    task automatic test_reset_mid_alloc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_00A0;
        @(posedge clk); @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        n_vec++;
        if (read_l2 !== 1'b1) begin
            n_err++; $display("FAIL mid_alloc_pre: read_l2 %b want 1", read_l2);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2} !== 7'b0 || l2_addr !== 32'h0 ||
            hit_cnt !== '0 || miss_cnt !== '0) begin
            n_err++; $display("FAIL mid_alloc_reset: flags %b addr %h cnt %0d/%0d want all 0", {hit, miss, cpu_ready, l1_we, l1_fill, write_l2, read_l2}, l2_addr, hit_cnt, miss_cnt);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        model_clear_lines(); mhit = 0; mmiss = 0;
        access(32'h0000_1040, 1'b0, 1'b0, "reload_after_reset");
        n_vec++;
        if (miss_cnt !== CW'(1)) begin
            n_err++; $display("FAIL reload_miss_count: misses %0d want 1", miss_cnt);
        end
    endtask

    task automatic test_inv_all();
        int sh, sm;
        access(32'h0000_1040, 1'b0, 1'b0, "pre_inv_hit");
        sh = mhit; sm = mmiss;
        inv_all = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040;
        @(posedge clk); @(negedge clk);
        inv_all = 1'b0; cpu_req = 1'b0;
        #1;
        n_vec++;
        if ({hit, miss, cpu_ready, write_l2, read_l2} !== 5'b0) begin
            n_err++; $display("FAIL inv_all_idle: flags %b want 00000", {hit, miss, cpu_ready, write_l2, read_l2});
        end
        model_clear_lines();
        access(32'h0000_1040, 1'b0, 1'b0, "post_inv_miss");
        n_vec++;
        if (hit_cnt !== CW'(sh) || miss_cnt !== CW'((sm < CNTMAX) ? sm + 1 : sm)) begin
            n_err++; $display("FAIL inv_all_counts: hits %0d misses %0d want %0d %0d", hit_cnt, miss_cnt, sh, sm + 1);
        end
    endtask

    task automatic test_random();
        logic [5:0]  idx_pool [4] = '{6'd0, 6'd1, 6'd2, 6'd63};
        logic [20:0] tg;
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                inv_all = 1'b1;
                @(posedge clk); @(negedge clk);
                inv_all = 1'b0;
                model_clear_lines();
            end
            tg = ($urandom_range(0, 3) == 0) ? 21'($urandom) : 21'($urandom_range(0, 5));
            a  = {tg, idx_pool[$urandom_range(0, 3)], 5'($urandom)};
            access(a, 1'($urandom), ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    task automatic test_back_to_back();
        access(32'h0000_3000, 1'b1, 1'b0, "b2b_first");
        for (int i = 0; i < 20; i++) begin
            access(32'h0000_3000 + 32'(i % 32), 1'($urandom), 1'b0, "b2b_hit");
        end
        n_vec++;
        if (hit_cnt !== CW'(CNTMAX)) begin
            n_err++; $display("FAIL hit_cnt_saturate: got %0d want %0d", hit_cnt, CNTMAX);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_victim();
        test_wb_ack_overlap();
        test_reset_mid_alloc();
        test_inv_all();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
